// File: rtl/mod_m_down_counter_with_delay_pkg.sv
// Shared sizing helpers for the prescaled mod-M counter family.
// Register widths are derived from the largest value they must hold.
package mod_m_down_counter_with_delay_pkg;

   // Number of bits needed to represent v. Returns at least 1, so a value of 0 still gets a bit.
   function automatic int clogb2(input int v);
      int r;
      r = 1;
      for (int i = 0; i < 31; i++) begin
         if ((v >> i) != 0) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/prescaler_mod_n.sv
// Mod-N prescaler: counts enabled clocks and flags the last one of every N.
// A synchronous clear restarts the count regardless of en.
module prescaler_mod_n
   import mod_m_down_counter_with_delay_pkg::*;
#(
   parameter  int N   = 50,
   localparam int qaL = clogb2(N - 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           clr,
   output logic [qaL-1:0] Qa,
   output logic           last
);

   localparam logic [qaL-1:0] QA_MAX = qaL'(N - 1);

   assign last = en & (Qa == QA_MAX);

   // The terminal value is compared before incrementing, so Qa never overflows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Qa <= '0;
      end else if (clr) begin
         Qa <= '0;
      end else if (en) begin
         Qa <= (Qa == QA_MAX) ? '0 : Qa + 1'b1;
      end
   end

endmodule

// File: rtl/mod_m_down_counter_with_delay.sv
// Prescaled mod-M down counter: Q decrements once every N enabled clocks and
// wraps from 0 to M-1 with a one-cycle wrap pulse. Preload has priority over stepping.
module mod_m_down_counter_with_delay
   import mod_m_down_counter_with_delay_pkg::*;
#(
   parameter  int M  = 11,
   parameter  int N  = 50,
   localparam int qL = clogb2(M - 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          load,
   input  logic [qL-1:0] load_val,
   output logic [qL-1:0] Q,
   output logic          step,
   output logic          zero,
   output logic          wrap
);

   localparam logic [qL-1:0] Q_MAX = qL'(M - 1);

   logic [qL-1:0] load_sat;

   prescaler_mod_n #(.N(N)) u_pre (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (load),
      .Qa   (),
      .last (step)
   );

   // load_val may encode values above M-1 when M is not a power of two.
   assign load_sat = (load_val > Q_MAX) ? Q_MAX : load_val;
   assign zero     = (Q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Q    <= Q_MAX;
         wrap <= 1'b0;
      end else begin
         wrap <= step & ~load & zero;
         if (load) begin
            Q <= load_sat;
         end else if (step) begin
            Q <= zero ? Q_MAX : Q - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mod_m_down_counter_with_delay.sv
// Scoreboard bench for the prescaled mod-M down counter (M=11, N=50).
// Stimulus queues expected states keyed by edge count; the monitor checks them on the falling edge.
module tb_mod_m_down_counter_with_delay;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] q;
   logic       step;
   logic       zero;
   logic       wrap;

   typedef struct {
      int    cyc;
      int    q;
      bit    wrap;
      bit    zero;
      bit    step;
      int    qa;
      string nm;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   edge_cnt = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   mod_m_down_counter_with_delay #(.M(11), .N(50)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .load     (load),
      .load_val (load_val),
      .Q        (q),
      .step     (step),
      .zero     (zero),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Monitor: every falling edge, compare all expectations due at the current edge count.
   always @(negedge clk) begin
      while (sb.size() != 0 && sb[0].cyc <= edge_cnt) begin
         mon_e = sb.pop_front();
         n_checks++;
         if (mon_e.cyc < edge_cnt) begin
            n_fail++;
            $display("FAIL %s: check for edge %0d missed, now at edge %0d", mon_e.nm, mon_e.cyc, edge_cnt);
         end else if (int'(q) != mon_e.q || wrap != mon_e.wrap || zero != mon_e.zero ||
                      step != mon_e.step ||
                      (mon_e.qa >= 0 && int'(dut.u_pre.Qa) != mon_e.qa)) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got Q=%0d wrap=%0b zero=%0b step=%0b Qa=%0d, expected Q=%0d wrap=%0b zero=%0b step=%0b Qa=%0d",
                     mon_e.nm, edge_cnt, q, wrap, zero, step, dut.u_pre.Qa,
                     mon_e.q, mon_e.wrap, mon_e.zero, mon_e.step, mon_e.qa);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_to(input int c);
      while (edge_cnt < c) tick();
   endtask

   task automatic expect_at(input int c, input int eq, input bit ew, input bit ez,
                            input bit es, input int eqa, input string nm);
      exp_t e;
      e.cyc  = c;
      e.q    = eq;
      e.wrap = ew;
      e.zero = ez;
      e.step = es;
      e.qa   = eqa;
      e.nm   = nm;
      sb.push_back(e);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 3000) begin
         tick();
         t++;
      end
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d checks never reached, expected 0 pending", sb.size());
         sb.delete();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int base;
      int cur;
      int c4;
      int c5;
      rst      = 1'b1;
      en       = 1'b0;
      load     = 1'b0;
      load_val = 4'd0;
      tick();
      tick();
      expect_at(edge_cnt, 10, 0, 0, 0, 0, "reset_state");
      drain();

      // 1: free-running countdown from reset
      do_reset();
      en   = 1'b1;
      base = edge_cnt;
      expect_at(base + 1,    10, 0, 0, 0, 1,  "t1_first_edge");
      expect_at(base + 49,   10, 0, 0, 1, 49, "t1_step_edge49");
      expect_at(base + 50,   9,  0, 0, 0, 0,  "t1_first_dec");
      expect_at(base + 500,  0,  0, 1, 0, 0,  "t1_reach_zero");
      expect_at(base + 549,  0,  0, 1, 1, 49, "t1_step_at_zero");
      expect_at(base + 550,  10, 1, 0, 0, 0,  "t1_wrap");
      expect_at(base + 551,  10, 0, 0, 0, 1,  "t1_wrap_one_cycle");
      expect_at(base + 1099, 0,  0, 1, 1, 49, "t1_before_wrap2");
      expect_at(base + 1100, 10, 1, 0, 0, 0,  "t1_wrap2");
      drain();

      // 2: load mid-count restarts the prescaler
      do_reset();
      en   = 1'b1;
      base = edge_cnt;
      tick_to(base + 170);
      expect_at(base + 170, 7, 0, 0, 0, 20, "t2_pre_load");
      expect_at(base + 171, 3, 0, 0, 0, 0,  "t2_loaded");
      expect_at(base + 220, 3, 0, 0, 1, 49, "t2_step_after_load");
      expect_at(base + 221, 2, 0, 0, 0, 0,  "t2_dec_after_load");
      load     = 1'b1;
      load_val = 4'd3;
      tick();
      load = 1'b0;
      drain();

      // 3: saturating load, then load of zero
      cur = edge_cnt;
      expect_at(cur + 1, 10, 0, 0, 0, 0, "t3_load_sat");
      expect_at(cur + 2, 0,  0, 1, 0, 0, "t3_load_zero");
      expect_at(cur + 3, 0,  0, 1, 0, 1, "t3_no_wrap");
      load     = 1'b1;
      load_val = 4'd15;
      tick();
      load_val = 4'd0;
      tick();
      load = 1'b0;

      // 4: load wins over a wrap step in the same cycle
      tick_to(cur + 51);
      expect_at(cur + 51, 0, 0, 1, 1, 49, "t4_step_at_zero");
      expect_at(cur + 52, 5, 0, 0, 0, 0,  "t4_load_over_wrap");
      expect_at(cur + 53, 5, 0, 0, 0, 1,  "t4_no_wrap_after");
      load     = 1'b1;
      load_val = 4'd5;
      tick();
      load = 1'b0;

      // 5: en low for 20 cycles freezes prescaler and counter
      c4 = edge_cnt;
      expect_at(c4 + 30, 5, 0, 0, 0, 30, "t5_freeze_start");
      expect_at(c4 + 40, 5, 0, 0, 0, 30, "t5_frozen");
      expect_at(c4 + 50, 5, 0, 0, 0, 30, "t5_no_dec_nominal");
      expect_at(c4 + 69, 5, 0, 0, 1, 49, "t5_late_step");
      expect_at(c4 + 70, 4, 0, 0, 0, 0,  "t5_late_dec");
      tick_to(c4 + 30);
      en = 1'b0;
      tick_to(c4 + 50);
      en = 1'b1;
      drain();

      // 6: asynchronous reset between edges
      c5 = c4 + 70;
      expect_at(c5 + 36, 4, 0, 0, 0, 36, "t6_pre_reset");
      tick_to(c5 + 37);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      expect_at(c5 + 37, 10, 0, 0, 0, 0,  "t6_async_reset");
      expect_at(c5 + 86, 10, 0, 0, 1, 49, "t6_step_after_reset");
      expect_at(c5 + 87, 9,  0, 0, 0, 0,  "t6_dec_after_reset");
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
